// File: rtl/jtopl_eg_timer.sv
// Envelope-generator timing source: shared envelope counter, slot index and
// a per-slot delay line returning each slot's previous-sweep counter LSB.
module jtopl_eg_timer #(
    parameter int SLOTS = 18,
    parameter int CNTW  = 15,
    parameter int DIV   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            zero,
    input  logic            cnt_lsb,
    output logic [CNTW-1:0] eg_cnt,
    output logic            cnt_in,
    output logic [4:0]      slot,
    output logic            eg_tick
);

    localparam int         DIV_E     = (DIV < 1) ? 1 : DIV;
    localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_E - 1);

    generate
        if (SLOTS > 32) begin : g_slots_chk
            $error("jtopl_eg_timer: SLOTS must not exceed 32");
        end
        if (DIV > 15) begin : g_div_chk
            $error("jtopl_eg_timer: DIV must be in 1..15");
        end
    endgenerate

    logic [CNTW-1:0]  eg_cnt_q, eg_cnt_d;
    logic [4:0]       slot_q, slot_d;
    logic [3:0]       div_q, div_d;
    logic [SLOTS-1:0] dl_q, dl_d;
    logic             tick_q, tick_d;
    logic             inc;

    // A counter step is issued on the zero edge that completes DIV sweeps.
    assign inc = zero && (div_q == DIV_LAST);

    always_comb begin
        eg_cnt_d = eg_cnt_q;
        slot_d   = slot_q;
        div_d    = div_q;
        dl_d     = dl_q;
        tick_d   = tick_q;
        if (cen) begin
            if (zero)
                slot_d = 5'd0;
            else if (slot_q == SLOT_LAST)
                slot_d = 5'd0;
            else
                slot_d = slot_q + 5'd1;

            if (zero)
                div_d = inc ? 4'd0 : div_q + 4'd1;

            eg_cnt_d = inc ? eg_cnt_q + 1'b1 : eg_cnt_q;
            tick_d   = inc;
            dl_d     = {dl_q[SLOTS-2:0], cnt_lsb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eg_cnt_q <= '0;
            slot_q   <= '0;
            div_q    <= '0;
            dl_q     <= '0;
            tick_q   <= 1'b0;
        end else begin
            eg_cnt_q <= eg_cnt_d;
            slot_q   <= slot_d;
            div_q    <= div_d;
            dl_q     <= dl_d;
            tick_q   <= tick_d;
        end
    end

    // The tail of the delay line is the bit this slot produced one sweep ago.
    assign cnt_in  = dl_q[SLOTS-1];
    assign eg_cnt  = eg_cnt_q;
    assign slot    = slot_q;
    assign eg_tick = tick_q;

endmodule

// File: tb/tb_jtopl_eg_timer.sv
// Scoreboard bench for jtopl_eg_timer: a DIV=1 and a DIV=3 instance share stimulus;
// the driver pushes the expected post-edge state, the monitor pops and compares.
module tb_jtopl_eg_timer;

  localparam int EW = 38;  // {slot, eg_cnt, cnt_in, eg_tick, eg_cnt3, eg_tick3}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
  logic zero = 1'b0;
  logic cnt_lsb = 1'b0;

  logic [14:0] eg_cnt, eg_cnt3;
  logic        cnt_in, cnt_in3, eg_tick, eg_tick3;
  logic [4:0]  slot, slot3;

  always #5 clk = ~clk;

  jtopl_eg_timer #(.SLOTS(18), .CNTW(15), .DIV(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .cnt_lsb(cnt_lsb),
    .eg_cnt(eg_cnt), .cnt_in(cnt_in), .slot(slot), .eg_tick(eg_tick)
  );

  jtopl_eg_timer #(.SLOTS(18), .CNTW(15), .DIV(3)) u_div3 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .cnt_lsb(cnt_lsb),
    .eg_cnt(eg_cnt3), .cnt_in(cnt_in3), .slot(slot3), .eg_tick(eg_tick3)
  );

  logic [EW-1:0] exp_q[$];
  event          mon_ev;
  int            n_vec = 0;
  int            n_err = 0;
  string         phase = "reset";

  // Reference state: slot, number of zero edges seen, last-edge zero, lsb history
  int   m_slot;
  int   m_zeros;
  logic m_tick;
  logic hist[$];

  function automatic logic [EW-1:0] model_vec();
    logic [4:0]  e_slot;
    logic [14:0] e_cnt, e_cnt3;
    logic        e_cin, e_tick, e_tick3;
    e_slot  = 5'(m_slot);
    e_cnt   = 15'(m_zeros);
    e_cnt3  = 15'(m_zeros / 3);
    e_tick  = m_tick;
    e_tick3 = m_tick && (m_zeros % 3 == 0);
    e_cin   = (hist.size() == 18) ? hist[0] : 1'b0;
    return {e_slot, e_cnt, e_cin, e_tick, e_cnt3, e_tick3};
  endfunction

  task automatic model_reset();
    m_slot  = 0;
    m_zeros = 0;
    m_tick  = 1'b0;
    hist.delete();
  endtask

  task automatic cyc(input logic c, input logic z, input logic l);
    cen = c; zero = z; cnt_lsb = l;
    @(posedge clk);
    if (c) begin
      m_tick = z;
      if (z) begin
        m_zeros++;
        m_slot = 0;
      end else begin
        m_slot = (m_slot + 1) % 18;
      end
      hist.push_back(l);
      if (hist.size() > 18) void'(hist.pop_front());
    end
    exp_q.push_back(model_vec());
    ->mon_ev;
    #1;
  endtask

  // Called at posedge+1: asserts reset between edges and checks outputs while held.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_vec());
    ->mon_ev;
    #2 rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic [EW-1:0] e, g;
    forever begin
      @(mon_ev);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {slot, eg_cnt, cnt_in, eg_tick, eg_cnt3, eg_tick3};
        n_vec++;
        if (g !== e) begin
          n_err++;
          $display("FAIL %s t=%0t: got slot=%0d cnt=%0d cnt_in=%0b tick=%0b cnt3=%0d tick3=%0b, exp slot=%0d cnt=%0d cnt_in=%0b tick=%0b cnt3=%0d tick3=%0b",
                   phase, $time, g[37:33], g[32:18], g[17], g[16], g[15:1], g[0],
                   e[37:33], e[32:18], e[17], e[16], e[15:1], e[0]);
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    #12;
    exp_q.push_back(model_vec());
    ->mon_ev;
    #5 rst_n = 1'b1;

    phase = "run100";
    for (int i = 0; i < 100; i++) cyc(1'b1, (i % 18) == 0, (i % 3) == 1);

    phase = "mid_reset";
    pulse_reset();

    phase = "cadence";
    for (int i = 0; i < 54; i++) cyc(1'b1, m_slot == 17, 1'b0);

    phase = "delay_line";
    for (int i = 0; i < 54; i++) cyc(1'b1, m_slot == 17, (i < 18) && (m_slot == 5));

    phase = "gating";
    for (int i = 0; i < 4; i++) cyc(1'b1, m_slot == 17, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 18; i++) begin
      if (m_slot == 9) break;
      cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    end

    phase = "resync";
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) cyc(1'b1, m_slot == 17, 1'($urandom_range(0, 1)));

    phase = "wrap";
    pulse_reset();
    for (int i = 0; i < 32769; i++) cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, m_slot == 17, 1'b0);

    #5;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked entries, exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtopl_eg_timer.md
Name: jtopl_eg_timer

Overview:
- Timing source for the envelope generator's per-slot rate-step logic.
- Produces the 15-bit free-running envelope counter, which all slots share and which advances once per completed slot sweep.
- Tracks the current slot index.
- Holds a per-slot delay line that returns, to each slot, the counter-LSB bit that slot produced in the previous sweep (cnt_in). The step logic uses this to detect counter-bit changes (sum_up).
- Sits in the EG pipeline, upstream of the step block and fed back from it.

Parameters:
- SLOTS, 18, number of operator slots per sweep (delay-line depth, slot counter modulus).
- CNTW, 15, envelope counter width.
- DIV, 1, number of complete sweeps per envelope-counter increment (1..15).

Ports:
- clk      input   1     system clock
- rst_n    input   1     asynchronous active-low reset
- cen      input   1     clock enable; all state advances only when high
- zero     input   1     sweep-start strobe, high during the cen cycle of slot 0
- cnt_lsb  input   1     LSB of the selected counter window for the slot currently in the step stage
- eg_cnt   output  CNTW  envelope counter, registered
- cnt_in   output  1     stored cnt_lsb of the current slot from the previous sweep, registered
- slot     output  5     current slot index, 0..SLOTS-1, registered
- eg_tick  output  1     one-cen-cycle pulse in the cycle eg_cnt takes a new value

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - eg_cnt=0, slot=0, cnt_in=0, eg_tick=0.
  - Sweep divider=0.
  - All SLOTS delay-line bits=0.
  - Release is synchronous to clk; the first update occurs on the first cen=1 edge after release.
- cen=0: every register holds, including eg_tick, which stays asserted if it was set.
- Slot counter, on each cen=1 edge:
  - zero=1 -> slot=0.
  - Otherwise slot = slot+1, wrapping from SLOTS-1 to 0.
  - A zero strobe arriving mid-sweep forces resync to 0; the delay line is not cleared.
- Sweep divider: on a cen=1 edge with zero=1, div increments. When div reaches DIV-1 it returns to 0 and a counter increment is issued in the same edge.
- Envelope counter:
  - On an increment edge, eg_cnt = eg_cnt+1 modulo 2^CNTW, so 32767 -> 0. The zero value is not skipped.
  - eg_tick is 1 for exactly the cen cycle following an increment edge, else 0.
  - eg_cnt is stable for the whole sweep, so all slots in a sweep see the same value.
- Delay line:
  - SLOTS-bit shift register advancing on each cen=1 edge.
  - The head captures cnt_lsb; cnt_in is the tail.
  - Net effect: cnt_in presented while slot=s equals the cnt_lsb sampled while slot=s exactly SLOTS cen cycles earlier.
  - Latency cnt_lsb -> cnt_in is SLOTS cen cycles, with no dependency on zero.
- Simultaneous events: zero=1 with slot=SLOTS-1 is the normal case. The slot wrap, divider step and counter increment all occur in one edge, with no extra cycle.
- Widths: slot is fixed at 5 bits. SLOTS>32 is illegal; flag it with an elaboration-time check. DIV=0 is treated as 1.

Test Plan:
- Reset mid-operation: run 100 cen cycles, then pulse rst_n low asynchronously between edges -> all outputs 0 immediately. After release, slot counts 0,1,2… from the next cen edge.
- Counter cadence, DIV=1, SLOTS=18: zero every 18 cen cycles -> eg_cnt increments 0,1,2 at each zero edge. eg_tick is high for exactly 1 cen cycle per sweep.
- Wrap: force eg_cnt to 32767 via 32767 sweeps (or a fast-forward bench mode) -> the next zero edge gives eg_cnt=0 and eg_tick=1.
- DIV=3: 9 sweeps -> eg_cnt=3, with increments only on the 3rd, 6th and 9th zero edges.
- Delay line: drive cnt_lsb=1 only while slot=5 in sweep N -> cnt_in=1 only while slot=5 in sweep N+1, and 0 on all other slots.
- Gating/resync: hold cen=0 for 7 cycles mid-sweep -> no output changes. Assert zero at slot=9 -> slot=0 on that edge, with eg_cnt incremented once.
